// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: tracks the EX and MEM slots,
// raises freeze/bubble/flush/stall and watches for memory waits that never end.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             isSrc2,
  input  logic             id_wb_en,
  input  logic             id_mem_en,
  input  logic [4:0]       id_dest,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             freez,
  output logic             bubble,
  output logic             flush,
  output logic             stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             dbg_mem_wait
);

  // Handshake: mem_ready is a one-cycle completion strobe for the access
  // sitting in MEM; while it is low and MEM holds a load/store, every pipeline
  // register (and both tracked slots) holds.

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_en;
    logic [4:0] dest;
  } slot_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  slot_t             ex_q, mem_q, ex_d;
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              src1_hit, src2_hit, hazard;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  always_comb begin
    src1_hit = slot_hit(ex_q, src1) | slot_hit(mem_q, src1);
    src2_hit = slot_hit(ex_q, src2) | slot_hit(mem_q, src2);
    hazard   = id_valid & (src1_hit | (isSrc2 & src2_hit));
    stall    = mem_q.valid & mem_q.mem_en & ~mem_ready;
    flush    = branch_taken & ~stall;
    bubble   = hazard & ~stall & ~flush;
    freez    = stall | bubble;
  end

  // A flushed or hazarded ID instruction is replaced by an invalid slot.
  always_comb begin
    ex_d = '0;
    if (id_valid & ~hazard & ~flush) begin
      ex_d.valid  = 1'b1;
      ex_d.wb_en  = id_wb_en;
      ex_d.mem_en = id_mem_en;
      ex_d.dest   = id_dest;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (stall) begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      mem_q        <= '0;
      state_q      <= RUN;
      wait_q       <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (!stall) begin
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
      state_q <= state_d;
      wait_q  <= wait_d;
      if (wait_d == WAIT_MAX) mem_timeout <= 1'b1;
      if (freez && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign dbg_mem_wait = (state_q == MEM_WAIT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized
// run compared against an instruction-level model of the two in-flight slots.
module tb_pipeline_ctrl;

  localparam int TO     = 8;
  localparam int CW     = 5;
  localparam int SC_MAX = (1 << CW) - 1;
  localparam int OW     = 6 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, isSrc2, id_wb_en, id_mem_en, branch_taken, mem_ready;
  logic [4:0]    src1, src2, id_dest;
  logic          freez, bubble, flush, stall, mem_timeout, dbg_mem_wait;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .isSrc2(isSrc2), .id_wb_en(id_wb_en), .id_mem_en(id_mem_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .freez(freez), .bubble(bubble),
    .flush(flush), .stall(stall), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .dbg_mem_wait(dbg_mem_wait)
  );

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    bit valid;
    bit wb;
    bit mem;
    int dest;
  } ins_t;

  ins_t m_pipe[2];   // [0] = in EX, [1] = in MEM
  bit   m_in_wait;   // the previous cycle was stalled on memory
  int   m_wait;
  bit   m_to;
  int   m_sc;
  logic [OW-1:0] exp_q[$];

  function automatic bit m_hit(input int r);
    for (int i = 0; i < 2; i++)
      if (m_pipe[i].valid && m_pipe[i].wb && m_pipe[i].dest == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard();
    return id_valid && (m_hit(int'(src1)) || (isSrc2 && m_hit(int'(src2))));
  endfunction

  function automatic bit m_stall();
    return m_pipe[1].valid && m_pipe[1].mem && !mem_ready;
  endfunction

  function automatic bit m_flush();
    return branch_taken && !m_stall();
  endfunction

  function automatic bit m_bubble();
    return m_hazard() && !m_stall() && !m_flush();
  endfunction

  function automatic bit m_freez();
    return m_stall() || m_bubble();
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 2; i++) m_pipe[i] = '{valid: 1'b0, wb: 1'b0, mem: 1'b0, dest: 0};
    m_in_wait = 1'b0;
    m_wait    = 0;
    m_to      = 1'b0;
    m_sc      = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // advance: one clock edge; the model steps with the inputs seen at that edge.
  task automatic advance();
    bit s, h, f, fz;
    s  = m_stall();
    h  = m_hazard();
    f  = m_flush();
    fz = m_freez();
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      if (!m_in_wait) m_wait = 0;
      else if (s && m_wait < TO) m_wait = m_wait + 1;
      if (m_wait == TO) m_to = 1'b1;
      m_in_wait = s;
      if (fz && m_sc < SC_MAX) m_sc = m_sc + 1;
      if (!s) begin
        m_pipe[1] = m_pipe[0];
        if (id_valid && !h && !f)
          m_pipe[0] = '{valid: 1'b1, wb: id_wb_en, mem: id_mem_en, dest: int'(id_dest)};
        else
          m_pipe[0] = '{valid: 1'b0, wb: 1'b0, mem: 1'b0, dest: 0};
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; src1 = 0; src2 = 0; isSrc2 = 0;
    id_wb_en = 0; id_mem_en = 0; id_dest = 0;
    branch_taken = 0; mem_ready = 1;
  endtask

  task automatic drive_id(input bit v, input int s1, input int s2, input bit i2,
                          input bit wb, input bit mm, input int d);
    id_valid = v; src1 = 5'(s1); src2 = 5'(s2); isSrc2 = i2;
    id_wb_en = wb; id_mem_en = mm; id_dest = 5'(d);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    advance();
    rst = 0;
    #1;
  endtask

  // A load with destination 4 is moved into the MEM slot.
  task automatic load_to_mem();
    drive_id(1, 0, 0, 0, 1, 1, 4);
    advance();
    idle();
    advance();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (freez !== 1'b0) begin n_fail++; $display("FAIL reset_freez: got %b want 0", freez); end
    n_cmp++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %b want 0", bubble); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    n_cmp++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_sc: got %0d want 0", stall_cycles); end
    n_cmp++; if (dbg_mem_wait !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", dbg_mem_wait); end
    branch_taken = 1; #1;
    n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush_follows: got %b want 1", flush); end
    idle();
  endtask

  task automatic test_raw_hazard();
    do_reset();
    drive_id(1, 0, 0, 0, 1, 0, 3);
    n_cmp++; if (freez !== 1'b0) begin n_fail++; $display("FAIL raw_issue_freez: got %b want 0", freez); end
    advance();
    drive_id(1, 3, 0, 0, 1, 0, 9);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if ({bubble, freez} !== 2'b11) begin n_fail++; $display("FAIL raw_bubble_%0d: got %b%b want 11", i, bubble, freez); end
      advance(); #1;
    end
    n_cmp++; if ({bubble, freez} !== 2'b00) begin n_fail++; $display("FAIL raw_release: got %b%b want 00", bubble, freez); end
    n_cmp++; if (stall_cycles !== CW'(2)) begin n_fail++; $display("FAIL raw_sc: got %0d want 2", stall_cycles); end
    advance();
    drive_id(1, 9, 0, 0, 0, 0, 0);
    n_cmp++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL raw_dep_in_ex: got %b want 1", bubble); end
    idle();
  endtask

  task automatic test_src2();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      drive_id(1, 0, 0, 0, 1, 0, 5);
      advance();
      drive_id(1, 7, 5, k[0], 0, 0, 0);
      n_cmp++; if (freez !== k[0]) begin n_fail++; $display("FAIL src2_is%0d: got %b want %0d", k, freez, k); end
    end
    idle();
  endtask

  task automatic test_load_stall();
    do_reset();
    load_to_mem();
    mem_ready = 0;
    drive_id(1, 4, 0, 0, 1, 0, 6);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({stall, freez, bubble} !== 3'b110) begin n_fail++; $display("FAIL ld_stall_%0d: got %b%b%b want 110", i, stall, freez, bubble); end
      n_cmp++; if (dbg_mem_wait !== (i > 0)) begin n_fail++; $display("FAIL ld_state_%0d: got %b want %0d", i, dbg_mem_wait, i > 0); end
      advance(); #1;
    end
    mem_ready = 1; #1;
    n_cmp++; if ({stall, bubble, dbg_mem_wait} !== 3'b011) begin n_fail++; $display("FAIL ld_ready: got %b%b%b want 011", stall, bubble, dbg_mem_wait); end
    advance(); #1;
    n_cmp++; if ({dbg_mem_wait, bubble} !== 2'b00) begin n_fail++; $display("FAIL ld_back_run: got %b%b want 00", dbg_mem_wait, bubble); end
    n_cmp++; if (stall_cycles !== CW'(5)) begin n_fail++; $display("FAIL ld_sc: got %0d want 5", stall_cycles); end
    idle();
  endtask

  task automatic test_timeout();
    int rise;
    rise = -1;
    do_reset();
    load_to_mem();
    mem_ready = 0; #1;
    for (int i = 0; i < 30; i++) begin
      if (mem_timeout === 1'b1 && rise < 0) rise = i;
      advance(); #1;
    end
    n_cmp++; if (rise !== 9) begin n_fail++; $display("FAIL to_rise_cycle: got %0d want 9", rise); end
    mem_ready = 1;
    for (int i = 0; i < 3; i++) advance();
    #1;
    n_cmp++; if ({mem_timeout, dbg_mem_wait} !== 2'b10) begin n_fail++; $display("FAIL to_sticky: got %b%b want 10", mem_timeout, dbg_mem_wait); end
    do_reset();
    n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_rst_clear: got %b want 0", mem_timeout); end
  endtask

  task automatic test_branch();
    do_reset();
    drive_id(1, 0, 0, 0, 1, 0, 3);
    advance();
    branch_taken = 1;
    drive_id(1, 3, 0, 0, 1, 0, 6);
    n_cmp++; if ({flush, bubble, freez} !== 3'b100) begin n_fail++; $display("FAIL br_hazard: got %b%b%b want 100", flush, bubble, freez); end
    advance();
    branch_taken = 0;
    drive_id(1, 6, 0, 0, 0, 0, 0);
    n_cmp++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL br_ex_invalid: got %b want 0", bubble); end
    do_reset();
    load_to_mem();
    mem_ready = 0; branch_taken = 1;
    drive_id(1, 4, 0, 0, 0, 0, 0);
    n_cmp++; if ({flush, stall, bubble} !== 3'b010) begin n_fail++; $display("FAIL br_stall: got %b%b%b want 010", flush, stall, bubble); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_to_mem();
    mem_ready = 0;
    drive_id(1, 4, 0, 0, 1, 0, 7);
    advance(); advance(); #1;
    n_cmp++; if (dbg_mem_wait !== 1'b1) begin n_fail++; $display("FAIL mid_in_wait: got %b want 1", dbg_mem_wait); end
    rst = 1;
    advance();
    rst = 0;
    drive_id(0, 4, 0, 0, 0, 0, 0);
    n_cmp++; if ({freez, bubble, flush, stall, mem_timeout, dbg_mem_wait} !== 6'b0) begin n_fail++; $display("FAIL mid_outputs: got %b%b%b%b%b%b want 000000", freez, bubble, flush, stall, mem_timeout, dbg_mem_wait); end
    n_cmp++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL mid_sc: got %0d want 0", stall_cycles); end
    idle();
  endtask

  task automatic test_random();
    logic [OW-1:0] got, want;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_ready    = ($urandom_range(0, 3) != 0);
      drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
               $urandom_range(0, 3));
      exp_q.push_back({m_freez(), m_bubble(), m_flush(), m_stall(), m_to, m_in_wait, CW'(m_sc)});
      got  = {freez, bubble, flush, stall, mem_timeout, dbg_mem_wait, stall_cycles};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rand_cycle_%0d: got %b want %b (fz bb fl st to wt sc)", i, got, want);
      end
      advance();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 0;
    idle();
    m_clear();
    @(negedge clk);
    test_reset();
    test_raw_hazard();
    test_src2();
    test_load_stall();
    test_timeout();
    test_branch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 64, meaning memory-wait cycles before mem_timeout sets.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall_cycles counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port id_valid, input, 1, meaning the ID stage holds a real instruction.
REQ-006 The block SHALL have ports src1 and src2, input, 5 each, the ID-stage source registers.
REQ-007 The block SHALL have port isSrc2, input, 1, meaning src2 is actually read by the ID instruction.
REQ-008 The block SHALL have ports id_wb_en, input, 1, and id_mem_en, input, 1: the ID instruction writes back, or accesses memory.
REQ-009 The block SHALL have port id_dest, input, 5, the ID-stage destination register.
REQ-010 The block SHALL have port branch_taken, input, 1, a taken branch resolved in EX this cycle.
REQ-011 The block SHALL have port mem_ready, input, 1, meaning the memory controller completes the MEM-stage access this cycle.
REQ-012 The block SHALL have port freez, output, 1, holding PC and the IF/ID register.
REQ-013 The block SHALL have port bubble, output, 1, loading a NOP into ID/EX.
REQ-014 The block SHALL have port flush, output, 1, clearing IF/ID and ID/EX.
REQ-015 The block SHALL have port stall, output, 1, holding PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-016 The block SHALL have port mem_timeout, output, 1, sticky memory-wait watchdog flag.
REQ-017 The block SHALL have port stall_cycles, output, CNT_W, counting cycles with freez high.

Function
REQ-018 The block SHALL track two in-flight slots, EX and MEM, each holding {valid, wb_en, mem_en, dest[4:0]}.
REQ-019 The block SHALL compute stall = MEM.valid & MEM.mem_en & !mem_ready, combinationally.
REQ-020 The block SHALL compute hazard = id_valid & (src1 hit | (isSrc2 & src2 hit)). A hit is an equal dest in any valid slot with wb_en=1; register 0 is not special.
REQ-021 The block SHALL drive flush = branch_taken & !stall.
REQ-022 The block SHALL drive bubble = hazard & !stall & !flush, and freez = stall | bubble.
REQ-023 Priority SHALL be stall over flush over hazard; at most one of bubble/flush is high in any cycle.
REQ-024 When stall=1, both slots SHALL hold their values.
REQ-025 Otherwise MEM SHALL load EX. EX SHALL load {1, id_wb_en, id_mem_en, id_dest} if id_valid & !hazard & !flush; else it loads valid=0.
REQ-026 An FSM SHALL have states RUN and MEM_WAIT.
REQ-027 RUN SHALL go to MEM_WAIT when stall=1. MEM_WAIT SHALL return to RUN in the cycle after mem_ready=1.
REQ-028 A wait counter SHALL clear in RUN and increment each MEM_WAIT cycle with stall=1.
REQ-029 mem_timeout SHALL set when the wait counter reaches MEM_TIMEOUT, and stay set until rst.
REQ-030 The wait counter SHALL saturate at MEM_TIMEOUT.
REQ-031 stall_cycles SHALL increment every cycle freez=1 and saturate at all-ones.
REQ-032 A hazard lasts at most 2 cycles absent stall: the matching slot drains MEM then leaves, with bubbles filling EX.
REQ-033 When branch_taken and hazard coincide, flush SHALL win. The ID instruction is discarded with no bubble and no freez.

Reset
REQ-034 When rst=1 at a clock edge: both slots go invalid, FSM enters RUN, wait counter=0, mem_timeout=0, stall_cycles=0.
REQ-035 With slots invalid after reset, freez, bubble and stall SHALL be 0; flush follows branch_taken.
REQ-036 rst SHALL override every other input, including mid-stall, with no pending wait or hazard surviving.

Verification
REQ-037 Issue ADD wb_en, dest=3, then id_valid with src1=3 next cycle -> bubble=freez=1 for exactly 2 cycles, then the dependent enters EX; stall_cycles=2.
REQ-038 Issue an instruction with dest=5 while ID has isSrc2=0, src2=5, src1=7 -> no freez; repeat with isSrc2=1 -> freez=1.
REQ-039 Load (mem_en=1) reaches MEM with mem_ready=0 for 4 cycles -> stall=1 for 4 cycles with slots held; mem_ready=1 -> stall=0 and FSM back to RUN the next cycle.
REQ-040 Hold mem_ready=0 with MEM_TIMEOUT=8 -> mem_timeout rises after 8 wait cycles and stays 1 after mem_ready; rst clears it.
REQ-041 branch_taken=1 with hazard=1 -> flush=1, bubble=0, freez=0, EX loads invalid; same with stall=1 -> flush=0, stall=1.
REQ-042 Assert rst during MEM_WAIT with hazard pending -> next cycle all outputs 0 and stall_cycles=0.
